// File: rtl/pending_enc_pkg.sv
// Shared constants and types for the 8-source pending-event encoder.
package pending_enc_pkg;

  localparam int unsigned N_SRC  = 8;
  localparam int unsigned CODE_W = 3;

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } state_e;

endpackage

// File: rtl/prio_enc8_3.sv
// Combinational 8-to-3 priority encoder; the highest set bit wins, idx=0 when nothing is set.
module prio_enc8_3
  import pending_enc_pkg::*;
(
  input  logic [N_SRC-1:0]  in,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Ascending scan: the last hit overwrites earlier ones, so the top bit wins.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (in[i]) begin
        idx = CODE_W'(i);
      end
    end
    any = |in;
  end

endmodule

// File: rtl/pending_encoder8_3.sv
// Captures rising request edges into a pending set and emits them as 3-bit codes over
// valid/ready, highest index first, with a sticky overflow for edges that hit a pending source.
module pending_encoder8_3
  import pending_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  req,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic              overflow,
  input  logic              ovf_clr
);

  logic [N_SRC-1:0]  req_q;
  logic [N_SRC-1:0]  pend_q, pend_d;
  logic [N_SRC-1:0]  rise;
  logic [N_SRC-1:0]  load_clr;
  logic [CODE_W-1:0] sel;
  logic [CODE_W-1:0] code_q, code_d;
  logic              any;
  logic              load;
  logic              ovf_q, ovf_d;
  logic              ovf_set;
  state_e            state_q, state_d;

  prio_enc8_3 u_prio (
    .in  (pend_q),
    .idx (sel),
    .any (any)
  );

  always_comb begin
    rise    = req & ~req_q;
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      StEmpty: begin
        if (any) begin
          load    = 1'b1;
          state_d = StFull;
        end
      end
      StFull: begin
        if (ready) begin
          if (any) begin
            load = 1'b1;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      default: state_d = StEmpty;
    endcase

    load_clr = load ? (N_SRC'(1) << sel) : '0;
    // A fresh edge re-pends its source even when that source is being loaded this cycle.
    pend_d   = (pend_q & ~load_clr) | rise;
    ovf_set  = |(rise & pend_q & ~load_clr);
    ovf_d    = ovf_set | (ovf_q & ~ovf_clr);
    code_d   = load ? sel : code_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      pend_q  <= '0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
      state_q <= StEmpty;
    end else begin
      req_q   <= req;
      pend_q  <= pend_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign code     = code_q;
  assign valid    = (state_q == StFull);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pending_encoder8_3.sv
// Directed self-checking bench for pending_encoder8_3.
module tb_pending_encoder8_3;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [2:0] code;
  logic       valid;
  logic       ready;
  logic       overflow;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;

  pending_encoder8_3 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .code     (code),
    .valid    (valid),
    .ready    (ready),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 8'h00;
    ready   = 1'b1;
    ovf_clr = 1'b0;
    #1;
    check("rst_valid", {7'd0, valid}, 8'd0);
    check("rst_code", {5'd0, code}, 8'd0);
    check("rst_ovf", {7'd0, overflow}, 8'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single pulse on req[5]
    req = 8'h20;
    step();
    req = 8'h00;
    check("p5_not_yet", {7'd0, valid}, 8'd0);
    step();
    check("p5_valid", {7'd0, valid}, 8'd1);
    check("p5_code", {5'd0, code}, 8'd5);
    step();
    check("p5_drained", {7'd0, valid}, 8'd0);

    // Three simultaneous rises, ready held high
    req = 8'h92;
    step();
    req = 8'h00;
    step();
    check("multi_c7", {4'd0, valid, code}, 8'h0F);
    step();
    check("multi_c4", {4'd0, valid, code}, 8'h0C);
    step();
    check("multi_c1", {4'd0, valid, code}, 8'h09);
    step();
    check("multi_empty", {7'd0, valid}, 8'd0);

    // Same stimulus with backpressure
    ready = 1'b0;
    req   = 8'h92;
    step();
    req = 8'h00;
    step();
    for (int i = 0; i < 5; i++) begin
      check("hold_c7", {4'd0, valid, code}, 8'h0F);
      step();
    end
    check("hold_c7_end", {4'd0, valid, code}, 8'h0F);
    ready = 1'b1;
    step();
    check("bp_c4", {4'd0, valid, code}, 8'h0C);
    step();
    check("bp_c1", {4'd0, valid, code}, 8'h09);
    step();
    check("bp_empty", {7'd0, valid}, 8'd0);

    // Overflow: req[3] fires twice while still pending behind code 0
    ready = 1'b0;
    req   = 8'h01;
    step();
    req = 8'h00;
    step();
    check("ovf_c0", {4'd0, valid, code}, 8'h08);
    req = 8'h08;
    step();
    req = 8'h00;
    step();
    check("ovf_none_yet", {7'd0, overflow}, 8'd0);
    req = 8'h08;
    step();
    req = 8'h00;
    check("ovf_set", {7'd0, overflow}, 8'd1);
    ready = 1'b1;
    step();
    check("ovf_c3", {4'd0, valid, code}, 8'h0B);
    step();
    check("ovf_single3", {7'd0, valid}, 8'd0);
    check("ovf_sticky", {7'd0, overflow}, 8'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared", {7'd0, overflow}, 8'd0);

    // req[2] rises on the same edge P[2] is loaded: re-pends, no overflow
    ready = 1'b0;
    req   = 8'h80;
    step();
    req = 8'h00;
    step();
    check("rp_c7", {4'd0, valid, code}, 8'h0F);
    req = 8'h04;
    step();
    req = 8'h00;
    step();
    req   = 8'h04;
    ready = 1'b1;
    step();
    req = 8'h00;
    check("rp_c2_first", {4'd0, valid, code}, 8'h0A);
    check("rp_no_ovf", {7'd0, overflow}, 8'd0);
    step();
    check("rp_c2_second", {4'd0, valid, code}, 8'h0A);
    step();
    check("rp_empty", {7'd0, valid}, 8'd0);
    check("rp_no_ovf_end", {7'd0, overflow}, 8'd0);

    // Asynchronous reset with a full pending set and a code in flight
    ready = 1'b0;
    req   = 8'h80;
    step();
    req = 8'h00;
    step();
    req = 8'hFF;
    step();
    check("pre_rst_pend", dut.pend_q, 8'hFF);
    check("pre_rst_valid", {7'd0, valid}, 8'd1);
    req = 8'h01;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {7'd0, valid}, 8'd0);
    check("arst_code", {5'd0, code}, 8'd0);
    check("arst_pend", dut.pend_q, 8'h00);
    check("arst_ovf", {7'd0, overflow}, 8'd0);
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    step();
    check("post_rst_lat1", {7'd0, valid}, 8'd0);
    step();
    check("post_rst_c0", {4'd0, valid, code}, 8'h08);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pending_encoder8_3.md
# pending_encoder8_3

Sequential 8-to-3 encoder that is the inverse of the team's 3-to-8 one-hot decoder. It sits on the request side of an 8-source event path. It captures rising edges on eight request lines into a pending register. It then emits each pending source as a 3-bit index, highest index first, over a valid/ready handshake. A served source is cleared only when its code is loaded into the output register, so no event is lost unless it re-fires while still pending.

## Interface
Parameters:
- none; width fixed at 8 sources / 3-bit code.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion synchronous to clk externally.
- req  input  8  request lines; a 0→1 transition on req[i] (sampled at clk) marks source i pending.
- code  output  3  index of the source being presented; meaningful only while valid=1.
- valid  output  1  code holds an unserved event.
- ready  input  1  consumer accepts code on a cycle with valid=1 and ready=1.
- overflow  output  1  sticky flag, set when a rising edge hits an already-pending source.
- ovf_clr  input  1  synchronous clear of overflow.

## Operation
- Edge detect: req_q <= req each cycle; rise = req & ~req_q.
- Pending register P[7:0] tracks edges not yet loaded to the output.
- Priority: highest set bit of P wins (index 7 highest). sel = that index. any = |P.
- Output FSM, 2 states:
  - EMPTY (valid=0): if any, load code<=sel, go to FULL, clear P[sel].
  - FULL (valid=1): code and valid are held stable while ready=0.
    - If ready=1 and any, reload code<=sel, stay FULL, clear P[sel].
    - If ready=1 and !any, go to EMPTY.
- P update per bit: P_next[i] = (P[i] & ~load_clr[i]) | rise[i]. A set caused by rise wins over a same-cycle clear, so an edge coinciding with its own load re-pends.
- Overflow: set when rise[i] & P[i] & ~load_clr[i] for any i. Otherwise hold. ovf_clr=1 clears it. A same-cycle set beats ovf_clr.
- Simultaneous rises on several bits: all are set pending. They are served in descending index order, one per accepted handshake.
- Reset mid-operation: all state returns to reset values immediately. Pending events and the in-flight code are discarded.

## Timing
- Reset values: code=3'd0, valid=0, overflow=0, P=8'h00, req_q=8'h00. A req bit already high when reset releases counts as a rising edge on the first clock.
- Latency, edge to output:
  - Edge sampled at clk edge N sets P at N.
  - Output loads at N+1; valid=1 after edge N+1. This gives 2 cycles when idle.
- Throughput: one code per cycle while ready=1 and P non-empty, with no bubble.
- valid never drops without a handshake. code never changes while valid=1 and ready=0.
- No combinational path from req or ready to any output; all outputs are registered.

## Structure
- Package pending_enc_pkg:
  - N_SRC=8, CODE_W=3.
  - State enum {EMPTY, FULL}.
- Sub-module prio_enc8_3 (combinational):
  - in [7:0] → idx [2:0] and any.
  - Highest-bit-wins.
  - Output idx=0 when in=0.
- Top level holds req_q, P, FSM, code, and the overflow register.

## Test plan
- Reset with req=8'h00, then pulse req[5] for one cycle, ready=1 → valid=1 with code=5 two cycles after the edge. valid=0 the cycle after acceptance.
- Rise on req=8'b1001_0010 in one cycle, ready=1 → codes 7, 4, 1 on consecutive cycles, then valid=0.
- Same stimulus with ready=0 for 5 cycles → code=7 held stable, valid=1 throughout. Releasing ready yields 7, 4, 1.
- req[3] pulses twice while code=3 is not yet loaded (ready=0, another source in output) → overflow=1 and only one code=3 is emitted. ovf_clr=1 → overflow=0 next cycle.
- req[2] rises the same cycle P[2] is loaded to the output → code=2 is emitted twice, and overflow stays 0.
- Assert rst_n=0 while P=8'hFF and valid=1 → valid, code, P, and overflow are all 0 asynchronously. With req held at 8'h01 at release, code=0 appears 2 cycles later.
